// File: rtl/edge_rate_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : edge_rate_classifier
//  Purpose  : Multi-channel edge-rate meter. Each asynchronous sensor line is
//             synchronised and edge-detected. Qualifying edges are counted over
//             a shared window of WINDOW_CYCLES enabled clocks. At window end
//             each channel's count is latched and classified against two
//             runtime thresholds, and a one-cycle valid strobe follows.
//  Revision : 1.0  initial release
// ============================================================================
module edge_rate_classifier #(
    parameter int CHANNELS      = 3,
    parameter int WINDOW_CYCLES = 25_000_000,
    parameter int CNT_W         = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int EDGE_MODE     = 0,
    parameter int IDLE_LEVEL    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       sensor,
    input  logic                      en,
    input  logic                      clear,
    input  logic [CNT_W-1:0]          thr_lo,
    input  logic [CNT_W-1:0]          thr_hi,
    output logic [CHANNELS*CNT_W-1:0] count_q,
    output logic [CHANNELS*2-1:0]     code,
    output logic [CHANNELS-1:0]       sat,
    output logic                      valid
);

    localparam int                     TMR_W       = $clog2(WINDOW_CYCLES);
    localparam logic [TMR_W-1:0]       c_TMR_LAST  = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]       c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic                   c_IDLE      = (IDLE_LEVEL != 0);
    localparam logic [SYNC_STAGES-1:0] c_SYNC_IDLE = {SYNC_STAGES{c_IDLE}};

    // ------------------------------------------------------------------------
    // Shared window timer
    // ------------------------------------------------------------------------
    logic [TMR_W-1:0] r_tmr_q;
    logic [TMR_W-1:0] r_tmr_d;
    logic             r_valid_q;
    logic             w_win_end;

    // clear outranks the window end, so a window never closes on a clear cycle
    assign w_win_end = en && !clear && (r_tmr_q == c_TMR_LAST);

    // Timer next state: clear restarts, en advances, window end wraps to zero
    always_comb begin
        r_tmr_d = r_tmr_q;
        if (clear) begin
            r_tmr_d = '0;
        end else if (en) begin
            if (w_win_end) begin
                r_tmr_d = '0;
            end else begin
                r_tmr_d = r_tmr_q + TMR_W'(1);
            end
        end
    end

    // Timer and valid strobe registers; valid trails the window end by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmr_q   <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_tmr_q   <= r_tmr_d;
            r_valid_q <= w_win_end;
        end
    end

    assign valid = r_valid_q;

    // ------------------------------------------------------------------------
    // Per-channel datapath
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync_q;
        logic                   r_prev_q;
        logic                   w_s;
        logic                   w_edge;
        logic                   w_at_max;
        logic [CNT_W-1:0]       r_live_q;
        logic [CNT_W-1:0]       r_live_d;
        logic [CNT_W-1:0]       w_final;
        logic                   r_satint_q;
        logic                   r_satint_d;
        logic                   w_final_sat;
        logic [1:0]             w_code;
        logic [CNT_W-1:0]       r_cnt_out_q;
        logic [1:0]             r_code_q;
        logic                   r_sat_out_q;

        // Synchroniser chain and previous sample; these track the line even
        // while counting is disabled so re-enabling never fabricates an edge
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync_q <= c_SYNC_IDLE;
                r_prev_q <= c_IDLE;
            end else begin
                r_sync_q <= {r_sync_q[SYNC_STAGES-2:0], sensor[gi]};
                r_prev_q <= w_s;
            end
        end

        assign w_s = r_sync_q[SYNC_STAGES-1];

        if (EDGE_MODE == 0) begin : g_fall
            assign w_edge = r_prev_q & ~w_s;
        end else if (EDGE_MODE == 1) begin : g_rise
            assign w_edge = ~r_prev_q & w_s;
        end else begin : g_both
            assign w_edge = r_prev_q ^ w_s;
        end

        // Count including this cycle's edge (saturating), the matching
        // saturation flag, its class, and the live-counter next state
        always_comb begin
            w_at_max    = (r_live_q == c_CNT_MAX);
            w_final     = r_live_q;
            if (w_edge && !w_at_max) begin
                w_final = r_live_q + CNT_W'(1);
            end
            // saturation means an edge arrived with nowhere left to count it
            w_final_sat = r_satint_q | (w_edge & w_at_max);

            if (w_final == '0) begin
                w_code = 2'd0;
            end else if (w_final <= thr_lo) begin
                w_code = 2'd1;
            end else if (w_final <= thr_hi) begin
                w_code = 2'd2;
            end else begin
                w_code = 2'd3;
            end

            r_live_d   = r_live_q;
            r_satint_d = r_satint_q;
            if (clear) begin
                r_live_d   = '0;
                r_satint_d = 1'b0;
            end else if (en) begin
                if (w_win_end) begin
                    r_live_d   = '0;
                    r_satint_d = 1'b0;
                end else begin
                    r_live_d   = w_final;
                    r_satint_d = w_final_sat;
                end
            end
        end

        // Live counter and its saturation bit
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_live_q   <= '0;
                r_satint_q <= 1'b0;
            end else begin
                r_live_q   <= r_live_d;
                r_satint_q <= r_satint_d;
            end
        end

        // Result latch: captured only when a window closes, held otherwise
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt_out_q <= '0;
                r_code_q    <= 2'd0;
                r_sat_out_q <= 1'b0;
            end else if (w_win_end) begin
                r_cnt_out_q <= w_final;
                r_code_q    <= w_code;
                r_sat_out_q <= w_final_sat;
            end
        end

        assign count_q[gi*CNT_W +: CNT_W] = r_cnt_out_q;
        assign code[2*gi +: 2]            = r_code_q;
        assign sat[gi]                    = r_sat_out_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_edge_rate_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_edge_rate_classifier
//  Purpose  : Directed bench for edge_rate_classifier. Two instances share the
//             control inputs: a wide-counter unit and a 3-bit-counter unit for
//             saturation. A window-level model predicts every output.
//  Revision : 1.0  initial release
// ============================================================================
module tb_edge_rate_classifier;

    localparam int W = 100;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       en     = 1'b1;
    logic       clear  = 1'b0;
    logic [2:0] sensor   = 3'b111;
    logic [2:0] sensor_s = 3'b111;
    logic [7:0] thr_lo = 8'd3;
    logic [7:0] thr_hi = 8'd6;

    logic [23:0] cnt0;
    logic [5:0]  code0;
    logic [2:0]  sat0;
    logic        valid0;
    logic [8:0]  cnt1;
    logic [5:0]  code1;
    logic [2:0]  sat1;
    logic        valid1;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    edge_rate_classifier #(
        .CHANNELS(3), .WINDOW_CYCLES(W), .CNT_W(8), .SYNC_STAGES(2),
        .EDGE_MODE(0), .IDLE_LEVEL(1)
    ) dut (
        .clk(clk), .rst(rst), .sensor(sensor), .en(en), .clear(clear),
        .thr_lo(thr_lo), .thr_hi(thr_hi),
        .count_q(cnt0), .code(code0), .sat(sat0), .valid(valid0)
    );

    edge_rate_classifier #(
        .CHANNELS(3), .WINDOW_CYCLES(W), .CNT_W(3), .SYNC_STAGES(2),
        .EDGE_MODE(0), .IDLE_LEVEL(1)
    ) dut_s (
        .clk(clk), .rst(rst), .sensor(sensor_s), .en(en), .clear(clear),
        .thr_lo(thr_lo[2:0]), .thr_hi(thr_hi[2:0]),
        .count_q(cnt1), .code(code1), .sat(sat1), .valid(valid1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit [1:0] classify(input int c, input int lo, input int hi);
        if (c == 0)       return 2'd0;
        else if (c <= lo) return 2'd1;
        else if (c <= hi) return 2'd2;
        else              return 2'd3;
    endfunction

    // ---------------- window-level model ----------------
    // raw[] history: hist[.][.][0] = line sampled one edge ago, [2] = three ago.
    // An edge becomes countable two edges after it is first sampled.
    int       live    [2][3];
    int       mcyc;
    bit       hist    [2][3][3];
    int       exp_cnt [2][3];
    bit [1:0] exp_code[2][3];
    bit       exp_sat [2][3];
    bit       exp_valid;

    always @(posedge clk) begin
        bit wend;
        bit e;
        bit raw;
        int maxv, lo, hi;
        wend = 1'b0;
        if (rst) begin
            mcyc      = 0;
            exp_valid = 1'b0;
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 3; i++) begin
                    live[d][i]     = 0;
                    exp_cnt[d][i]  = 0;
                    exp_code[d][i] = 2'd0;
                    exp_sat[d][i]  = 1'b0;
                    for (int k = 0; k < 3; k++) hist[d][i][k] = 1'b1;
                end
            end
        end else begin
            if (clear) begin
                mcyc = 0;
            end else if (en) begin
                mcyc++;
                if (mcyc == W) begin
                    wend = 1'b1;
                    mcyc = 0;
                end
            end
            for (int d = 0; d < 2; d++) begin
                maxv = (d == 0) ? 255 : 7;
                lo   = (d == 0) ? int'(thr_lo) : int'(thr_lo[2:0]);
                hi   = (d == 0) ? int'(thr_hi) : int'(thr_hi[2:0]);
                for (int i = 0; i < 3; i++) begin
                    e = hist[d][i][2] & ~hist[d][i][1];
                    if (clear) begin
                        live[d][i] = 0;
                    end else if (en) begin
                        live[d][i] += int'(e);
                        if (wend) begin
                            exp_cnt[d][i]  = (live[d][i] > maxv) ? maxv : live[d][i];
                            exp_sat[d][i]  = (live[d][i] > maxv);
                            exp_code[d][i] = classify(exp_cnt[d][i], lo, hi);
                            live[d][i]     = 0;
                        end
                    end
                    raw = (d == 0) ? sensor[i] : sensor_s[i];
                    hist[d][i][2] = hist[d][i][1];
                    hist[d][i][1] = hist[d][i][0];
                    hist[d][i][0] = raw;
                end
            end
            exp_valid = wend;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wide ch%0d count", i), int'(cnt0[i*8 +: 8]), exp_cnt[0][i]);
            chk($sformatf("wide ch%0d code", i),  int'(code0[2*i +: 2]), int'(exp_code[0][i]));
            chk($sformatf("wide ch%0d sat", i),   int'(sat0[i]), int'(exp_sat[0][i]));
            chk($sformatf("narrow ch%0d count", i), int'(cnt1[i*3 +: 3]), exp_cnt[1][i]);
            chk($sformatf("narrow ch%0d code", i),  int'(code1[2*i +: 2]), int'(exp_code[1][i]));
            chk($sformatf("narrow ch%0d sat", i),   int'(sat1[i]), int'(exp_sat[1][i]));
        end
        chk("wide valid", int'(valid0), int'(exp_valid));
        chk("narrow valid", int'(valid1), int'(exp_valid));
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulses(input int a0, input int a1, input int a2,
                          input int b0, input int b1, input int b2);
        int mx;
        mx = a0;
        if (a1 > mx) mx = a1;
        if (a2 > mx) mx = a2;
        if (b0 > mx) mx = b0;
        if (b1 > mx) mx = b1;
        if (b2 > mx) mx = b2;
        for (int k = 0; k < mx; k++) begin
            @(negedge clk);
            sensor   = {!(a2 > k), !(a1 > k), !(a0 > k)};
            sensor_s = {!(b2 > k), !(b1 > k), !(b0 > k)};
            @(negedge clk);
            sensor   = 3'b111;
            sensor_s = 3'b111;
        end
    endtask

    task automatic wait_valid(input int bound, output int at);
        at = -1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (valid0) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic goto_cyc(input int target);
        int k;
        k = 0;
        while (cyc != target && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("reach cycle", cyc, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int rel, at, v, nv;
        repeat (3) @(negedge clk);
        chk("reset count", int'(cnt0), 0);
        chk("reset code", int'(code0), 0);
        chk("reset valid", int'(valid0), 0);
        rst = 1'b0;
        rel = cyc;

        // Window 1: classification and saturation
        pulses(0, 2, 9, 0, 2, 10);
        wait_valid(300, at);
        chk("w1 period", at - rel, 100);
        chk("w1 wide count", int'(cnt0), int'({8'd9, 8'd2, 8'd0}));
        chk("w1 wide code", int'(code0), int'({2'd3, 2'd1, 2'd0}));
        chk("w1 wide sat", int'(sat0), 0);
        chk("w1 narrow count", int'(cnt1), int'({3'd7, 3'd2, 3'd0}));
        chk("w1 narrow sat", int'(sat1), 4);
        v = at;

        // Window 2: threshold boundaries, saturation clears
        pulses(3, 6, 7, 2, 0, 1);
        wait_valid(300, at);
        chk("w2 period", at - v, 100);
        chk("w2 wide count", int'(cnt0), int'({8'd7, 8'd6, 8'd3}));
        chk("w2 wide code", int'(code0), int'({2'd3, 2'd2, 2'd1}));
        chk("w2 narrow count", int'(cnt1), int'({3'd1, 3'd0, 3'd2}));
        chk("w2 narrow sat", int'(sat1), 0);
        v = at;

        // Window 3: en pause with toggles, then rising-only edges
        repeat (10) @(negedge clk);
        en = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (n == 5) begin
                sensor = 3'b000; sensor_s = 3'b000;
            end else if (n == 6) begin
                sensor = 3'b111; sensor_s = 3'b111;
            end else if (n == 10) begin
                sensor = 3'b000; sensor_s = 3'b000;
            end else if (n == 49) begin
                en = 1'b1;
                sensor = 3'b111; sensor_s = 3'b111;
            end
        end
        wait_valid(300, at);
        chk("w3 period", at - v, 150);
        chk("w3 wide count", int'(cnt0), 0);
        chk("w3 narrow count", int'(cnt1), 0);
        v = at;

        // Window 4: edge counted on the terminal cycle
        goto_cyc(v + 97);
        sensor = 3'b110; sensor_s = 3'b110;
        @(negedge clk);
        sensor = 3'b111; sensor_s = 3'b111;
        wait_valid(300, at);
        chk("w4 period", at - v, 100);
        chk("w4 wide count", int'(cnt0), 1);
        chk("w4 wide code", int'(code0), 1);
        chk("w4 narrow count", int'(cnt1), 1);
        v = at;

        // Window 5: clear at cycle 60 restarts the window
        pulses(0, 4, 0, 0, 4, 0);
        goto_cyc(v + 59);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("w5 held count", int'(cnt0), 1);
        pulses(0, 2, 0, 0, 2, 0);
        wait_valid(300, at);
        chk("w5 period", at - v, 160);
        chk("w5 wide count", int'(cnt0), int'({8'd0, 8'd2, 8'd0}));
        chk("w5 wide code", int'(code0), int'({2'd0, 2'd1, 2'd0}));
        chk("w5 narrow count", int'(cnt1), int'({3'd0, 3'd2, 3'd0}));
        v = at;

        // Window 6: reset at cycle 40 aborts everything
        pulses(0, 0, 3, 0, 0, 3);
        goto_cyc(v + 39);
        rst = 1'b1;
        @(negedge clk);
        chk("rst wide count", int'(cnt0), 0);
        chk("rst wide code", int'(code0), 0);
        chk("rst wide sat", int'(sat0), 0);
        chk("rst valid", int'(valid0), 0);
        chk("rst narrow count", int'(cnt1), 0);
        chk("rst narrow sat", int'(sat1), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nv = 0;
        for (int k = 0; k < 95; k++) begin
            @(negedge clk);
            if (valid0 || valid1) nv++;
        end
        chk("no valid after rst", nv, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
